prt_scaler_lbf_wr: RTL

Write-side controller that feeds the scaler line buffer from an upstream ready/valid pixel stream. It aligns to frame start and issues the one-cycle frame-start pulse that clears the buffer. It then transfers whole lines only when the buffer reports ready, back-pressuring the source between lines. It enforces the programmed line length and line count, and flags malformed lines.

---
 rtl/prt_scaler_lbf_wr.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/prt_scaler_lbf_wr.sv
// ---------------------------------------------------------------------------
// prt_scaler_lbf_wr
//
// Write-side controller for the scaler line buffer. It takes an upstream
// ready/valid pixel stream and does the following:
//   - aligns to start of frame;
//   - issues a one-cycle frame-start pulse that clears the buffer;
//   - moves whole lines into the buffer, and only when the buffer reports
//     room for one;
//   - enforces the programmed line length and line count;
//   - flags short and long lines in a sticky error register.
//
// Ports
//   CLK_IN         clock
//   RST_IN         asynchronous active-low reset
//   CTL_RUN_IN     run enable; low returns the controller to IDLE
//   CTL_HWRDS_IN   words per line, latched at frame start (0 treated as 1)
//   CTL_VLINES_IN  lines per frame, latched at frame start (0 treated as 1)
//   SRC_DAT_IN     source data word
//   SRC_VLD_IN     source valid
//   SRC_SOF_IN     start of frame (first word), qualified by valid
//   SRC_EOL_IN     end of line (last word), qualified by valid
//   SRC_RDY_OUT    source ready, combinational from state/run/SOF decode
//   LBF_RDY_IN     line buffer can take one full line
//   CTL_FS_OUT     frame-start pulse to the line buffer
//   VID_DAT_OUT    registered write data to the line buffer
//   VID_DE_OUT     registered write enable to the line buffer
//   STA_ERR_OUT    sticky errors: [0] short line, [1] long line
// ---------------------------------------------------------------------------
module prt_scaler_lbf_wr #(
    parameter int P_PPC     = 4,
    parameter int P_BPC     = 8,
    parameter int P_HWRDS_W = 12
) (
    input  logic                     CLK_IN,
    input  logic                     RST_IN,
    input  logic                     CTL_RUN_IN,
    input  logic [P_HWRDS_W-1:0]     CTL_HWRDS_IN,
    input  logic [P_HWRDS_W-1:0]     CTL_VLINES_IN,
    input  logic [P_PPC*P_BPC-1:0]   SRC_DAT_IN,
    input  logic                     SRC_VLD_IN,
    input  logic                     SRC_SOF_IN,
    input  logic                     SRC_EOL_IN,
    output logic                     SRC_RDY_OUT,
    input  logic                     LBF_RDY_IN,
    output logic                     CTL_FS_OUT,
    output logic [P_PPC*P_BPC-1:0]   VID_DAT_OUT,
    output logic                     VID_DE_OUT,
    output logic [1:0]               STA_ERR_OUT
);

    localparam int                   C_DW  = P_PPC * P_BPC;
    localparam logic [P_HWRDS_W-1:0] C_ONE = {{(P_HWRDS_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF_WAIT,
        ST_FS,
        ST_GUARD,
        ST_LINE_WAIT,
        ST_LINE,
        ST_DISCARD
    } state_t;

    state_t                 state_reg, state_next;
    logic [P_HWRDS_W-1:0]   wc_reg, wc_next;
    logic [P_HWRDS_W-1:0]   lc_reg, lc_next;
    logic [P_HWRDS_W-1:0]   hwrds_reg, hwrds_next;
    logic [P_HWRDS_W-1:0]   vlines_reg, vlines_next;
    logic                   guard_reg, guard_next;
    logic [1:0]             err_reg, err_next;
    logic [C_DW-1:0]        vid_dat_reg, vid_dat_next;
    logic                   vid_de_reg, vid_de_next;

    logic                   sof_hit;
    logic                   first_word;
    logic                   src_rdy;
    logic                   accept;
    logic [P_HWRDS_W-1:0]   wc_inc;
    logic [P_HWRDS_W-1:0]   lc_inc;
    logic                   last_word;
    state_t                 eol_state;

    // Ready decode. A valid SOF in SOF_WAIT, DISCARD or mid-LINE is left
    // pending: ready drops in the same cycle so the SOF word survives the
    // frame-start sequence and becomes the first word of the new frame.
    always_comb begin
        sof_hit    = SRC_VLD_IN & SRC_SOF_IN;
        first_word = (wc_reg == '0) && (lc_reg == '0);
        src_rdy    = 1'b0;
        case (state_reg)
            ST_SOF_WAIT: src_rdy = ~sof_hit;
            ST_LINE:     src_rdy = ~(sof_hit & ~first_word);
            ST_DISCARD:  src_rdy = ~sof_hit;
            default:     src_rdy = 1'b0;
        endcase
        src_rdy = src_rdy & CTL_RUN_IN;
        accept  = SRC_VLD_IN & src_rdy;
        wc_inc    = wc_reg + C_ONE;
        lc_inc    = lc_reg + C_ONE;
        last_word = (wc_inc == hwrds_reg);
        eol_state = (lc_inc == vlines_reg) ? ST_SOF_WAIT : ST_LINE_WAIT;
    end

    // Next-state and datapath
    always_comb begin
        state_next   = state_reg;
        wc_next      = wc_reg;
        lc_next      = lc_reg;
        hwrds_next   = hwrds_reg;
        vlines_next  = vlines_reg;
        guard_next   = guard_reg;
        err_next     = err_reg;
        vid_dat_next = vid_dat_reg;
        vid_de_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_SOF_WAIT;
            end

            ST_SOF_WAIT: begin
                if (sof_hit) begin
                    state_next = ST_FS;
                end
            end

            ST_FS: begin
                hwrds_next  = (CTL_HWRDS_IN == '0) ? C_ONE : CTL_HWRDS_IN;
                vlines_next = (CTL_VLINES_IN == '0) ? C_ONE : CTL_VLINES_IN;
                wc_next     = '0;
                lc_next     = '0;
                err_next    = 2'b00;
                guard_next  = 1'b0;
                state_next  = ST_GUARD;
            end

            // Two idle cycles while the buffer's registered clear settles
            ST_GUARD: begin
                guard_next = 1'b1;
                if (guard_reg) begin
                    state_next = ST_LINE_WAIT;
                end
            end

            ST_LINE_WAIT: begin
                wc_next = '0;
                if (LBF_RDY_IN) begin
                    state_next = ST_LINE;
                end
            end

            ST_LINE: begin
                if (sof_hit && !first_word) begin
                    state_next = ST_FS;
                end else if (accept) begin
                    vid_de_next  = 1'b1;
                    vid_dat_next = SRC_DAT_IN;
                    if (SRC_EOL_IN) begin
                        if (!last_word) begin
                            err_next[0] = 1'b1;
                        end
                        wc_next    = '0;
                        lc_next    = lc_inc;
                        state_next = eol_state;
                    end else if (last_word) begin
                        // Line already full: keep the word, drop the rest
                        err_next[1] = 1'b1;
                        wc_next     = '0;
                        state_next  = ST_DISCARD;
                    end else begin
                        wc_next = wc_inc;
                    end
                end
            end

            ST_DISCARD: begin
                if (sof_hit) begin
                    state_next = ST_FS;
                end else if (accept && SRC_EOL_IN) begin
                    lc_next    = lc_inc;
                    state_next = eol_state;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (!CTL_RUN_IN) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_reg   <= ST_IDLE;
            wc_reg      <= '0;
            lc_reg      <= '0;
            hwrds_reg   <= '0;
            vlines_reg  <= '0;
            guard_reg   <= 1'b0;
            err_reg     <= 2'b00;
            vid_dat_reg <= '0;
            vid_de_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wc_reg      <= wc_next;
            lc_reg      <= lc_next;
            hwrds_reg   <= hwrds_next;
            vlines_reg  <= vlines_next;
            guard_reg   <= guard_next;
            err_reg     <= err_next;
            vid_dat_reg <= vid_dat_next;
            vid_de_reg  <= vid_de_next;
        end
    end

    assign SRC_RDY_OUT = src_rdy;
    assign CTL_FS_OUT  = (state_reg == ST_FS);
    assign VID_DAT_OUT = vid_dat_reg;
    assign VID_DE_OUT  = vid_de_reg;
    assign STA_ERR_OUT = err_reg;

endmodule
